sd_1011_gen: RTL and testbench
==============================

Name: sd_1011_gen

Overview:
- Serial sequence transmitter; the stimulus end of the overlapping 1011 Mealy detector.
- Emits a programmable N-bit pattern (default 1011), MSB first, one bit per clock on `signal`.
- Supports repeat count, idle-gap insertion and overlapped back-to-back framing, so a detector can be driven with known hit counts.
- Sits in front of sd_1011-class detectors in FSM test and bring-up chains.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, pattern emitted MSB first.
- OVL_LEN, 1, leading bits skipped on overlapped follow-on frames (0..PAT_W-1). 1 matches the 1011 self-overlap.
- GAP_W, 4, width of the gap length input.
- CNT_W, 8, width of the repeat count input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a burst; sampled only in IDLE.
- abort  in  1  synchronous burst cancel.
- repeat_cnt  in  CNT_W  frames per burst; 0 is treated as 1.
- gap  in  GAP_W  idle cycles between frames.
- overlap  in  1  overlapped framing enable; honoured only when gap==0.
- signal  out  1  serial pattern bit.
- sig_valid  out  1  high while `signal` carries a pattern bit.
- frame_start  out  1  high with the first emitted bit of every frame.
- busy  out  1  burst in progress (SEND or GAP).
- done  out  1  one-cycle pulse after the last bit of a completed burst.

Behaviour:
- Reset (rst=0, async): state=IDLE; signal, sig_valid, frame_start, busy, done all 0. Applies mid-burst; no done pulse is produced.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE, SEND, GAP. Encoding is 2 bits from the shared package.
- IDLE:
  - Outputs 0, except done may be high for exactly one cycle on entry from a completed burst.
  - Edge where start=1: latch repeat_cnt (0→1), gap and overlap into internal registers. Set bit_idx=PAT_W-1 and frames_left=latched count, enter SEND.
  - On that same edge: signal=PATTERN[PAT_W-1], sig_valid=1, frame_start=1, busy=1. Latency is 1 cycle from start sampled to first bit visible.
- SEND:
  - Each edge emits PATTERN[bit_idx] with sig_valid=1 and busy=1, then decrements bit_idx.
  - frame_start is high only on a frame's first emitted bit.
- End of frame (bit_idx==0 emitted): decrement frames_left.
  - frames_left becomes 0: next edge goes to IDLE with signal=0, sig_valid=0, busy=0, done=1 for one cycle.
  - Frames remain and latched gap>0: enter GAP for exactly `gap` cycles with signal=0, sig_valid=0, busy=1.
  - Frames remain and gap==0, overlap=0: next edge starts the next frame at bit PAT_W-1, with no dead cycle.
  - Frames remain and gap==0, overlap=1: next frame starts at bit PAT_W-1-OVL_LEN. frame_start is high on that first emitted bit.
- GAP: gap counter decrements each cycle. After the last gap cycle, the next edge emits the next frame's first bit (full frame; overlap ignored).
- abort=1 in SEND or GAP: next edge goes to IDLE with all outputs 0 and no done pulse. In IDLE, abort has no effect.
- Simultaneous start and abort in IDLE: start wins; abort is only checked in SEND/GAP.
- start while busy: ignored. Latched configuration is immune to input changes mid-burst.
- Counters:
  - frames_left is CNT_W bits, gap counter is GAP_W bits, bit_idx is clog2(PAT_W) bits.
  - No wrap-around is permitted; the counters saturate at 0 by construction.
- done and the start of a new burst: done is high in the IDLE cycle after the burst. A start sampled in that same cycle is accepted normally.

Decomposition:
- Shared package sd_fsm_pkg holds:
  - state encodings GEN_IDLE/GEN_SEND/GEN_GAP (2'b00/01/10);
  - constant SD_PAT_1011 = 4'b1011 and its overlap length SD_OVL_1011 = 1.
  The detector reuses these constants.
- One natural sub-module: sd_gen_cnt. It is a loadable down-counter with a zero flag and is instantiated twice, for frames_left and for the gap counter. The FSM stays in the top module.

Test Plan:
- Reset release, start=1 for 1 cycle, repeat_cnt=1, gap=0 → signal=1,0,1,1 with sig_valid=1111 and frame_start on cycle 1; then done=1 for one cycle, busy=0.
- repeat_cnt=3, gap=0, overlap=1 → signal stream 1011011011 (10 bits), frame_start on bits 1,5,8. A chained sd_1011 detector fires exactly 3 times.
- repeat_cnt=2, gap=3, overlap=1 → 1011, then 3 cycles sig_valid=0/busy=1, then full 1011. Overlap is ignored and exactly 11 busy cycles elapse.
- repeat_cnt=0 → identical to repeat_cnt=1 (4 bits, one done). start pulses during the burst → no restart, no extra frames.
- abort asserted on bit 3 of frame 2 (repeat_cnt=4) → next edge all outputs 0, no done; a fresh start then produces a full burst.
- rst driven low mid-GAP, asynchronously between clock edges → outputs 0 immediately. After release, the block stays IDLE until start.

Source files
------------

// File: rtl/sd_fsm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_fsm_pkg : shared state encodings and pattern constants for sd_1011 blocks
// Revision   : 1.0
// ---------------------------------------------------------------------------
package sd_fsm_pkg;

   typedef enum logic [1:0] {
      GEN_IDLE = 2'b00,
      GEN_SEND = 2'b01,
      GEN_GAP  = 2'b10
   } gen_state_t;

   localparam logic [3:0] SD_PAT_1011 = 4'b1011;
   localparam int         SD_OVL_1011 = 1;

endpackage
`default_nettype wire

// File: rtl/sd_gen_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_gen_cnt : loadable down-counter that holds at zero, with a zero flag
// Revision   : 1.0
// ---------------------------------------------------------------------------
module sd_gen_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sd_1011_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_1011_gen : serial pattern transmitter with repeat, gap and overlap framing
// Revision    : 1.0
// ---------------------------------------------------------------------------
module sd_1011_gen
   import sd_fsm_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = SD_PAT_1011,
   parameter int               OVL_LEN = SD_OVL_1011,
   parameter int               GAP_W   = 4,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   input  logic             overlap,
   output logic             signal,
   output logic             sig_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int               IDX_W       = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] c_idx_first = IDX_W'(PAT_W - 1);
   localparam logic [IDX_W-1:0] c_idx_ovl   = IDX_W'(PAT_W - 1 - OVL_LEN);

   gen_state_t       r_state;
   logic [IDX_W-1:0] r_bit_idx;
   logic [GAP_W-1:0] r_gap;
   logic             r_ovl;

   logic             w_frame_end;
   logic             w_fl_load;
   logic             w_fl_zero;
   logic             w_gp_load;
   logic             w_gp_dec;
   logic             w_gp_zero;
   logic [CNT_W-1:0] w_cnt_m1;
   logic [GAP_W-1:0] w_gap_m1;
   logic [IDX_W-1:0] w_idx_dec;
   logic [IDX_W-1:0] w_idx_next;

   // Frame counter holds the frames still to follow the current one.
   assign w_cnt_m1    = (repeat_cnt == '0) ? '0 : repeat_cnt - CNT_W'(1);
   assign w_gap_m1    = r_gap - GAP_W'(1);
   assign w_idx_dec   = r_bit_idx - IDX_W'(1);
   assign w_idx_next  = r_ovl ? c_idx_ovl : c_idx_first;
   assign w_frame_end = (r_state == GEN_SEND) && !abort && (r_bit_idx == '0);
   assign w_fl_load   = (r_state == GEN_IDLE) && start;
   assign w_gp_load   = w_frame_end && !w_fl_zero && (r_gap != '0);
   assign w_gp_dec    = (r_state == GEN_GAP) && !abort;

   sd_gen_cnt #(.W(CNT_W)) u_frames_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_fl_load),
      .i_load_val (w_cnt_m1),
      .i_dec      (w_frame_end),
      .o_zero     (w_fl_zero)
   );

   sd_gen_cnt #(.W(GAP_W)) u_gap_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_gp_load),
      .i_load_val (w_gap_m1),
      .i_dec      (w_gp_dec),
      .o_zero     (w_gp_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= GEN_IDLE;
         r_bit_idx   <= '0;
         r_gap       <= '0;
         r_ovl       <= 1'b0;
         signal      <= 1'b0;
         sig_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         signal      <= 1'b0;
         sig_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         case (r_state)
            GEN_IDLE: begin
               if (start) begin
                  r_gap       <= gap;
                  r_ovl       <= overlap;
                  r_state     <= GEN_SEND;
                  r_bit_idx   <= c_idx_first;
                  signal      <= PATTERN[c_idx_first];
                  sig_valid   <= 1'b1;
                  frame_start <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            GEN_SEND: begin
               if (abort) begin
                  r_state <= GEN_IDLE;
               end else if (r_bit_idx != '0) begin
                  r_bit_idx <= w_idx_dec;
                  signal    <= PATTERN[w_idx_dec];
                  sig_valid <= 1'b1;
                  busy      <= 1'b1;
               end else if (w_fl_zero) begin
                  r_state <= GEN_IDLE;
                  done    <= 1'b1;
               end else if (r_gap != '0) begin
                  r_state <= GEN_GAP;
                  busy    <= 1'b1;
               end else begin
                  r_bit_idx   <= w_idx_next;
                  signal      <= PATTERN[w_idx_next];
                  sig_valid   <= 1'b1;
                  frame_start <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            GEN_GAP: begin
               if (abort) begin
                  r_state <= GEN_IDLE;
               end else if (w_gp_zero) begin
                  r_state     <= GEN_SEND;
                  r_bit_idx   <= c_idx_first;
                  signal      <= PATTERN[c_idx_first];
                  sig_valid   <= 1'b1;
                  frame_start <= 1'b1;
                  busy        <= 1'b1;
               end else begin
                  busy <= 1'b1;
               end
            end
            default: r_state <= GEN_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_1011_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sd_1011_gen : scoreboard bench for sd_1011_gen against a frame-level model
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_sd_1011_gen;

   typedef logic [4:0] exp_t;   // {signal, sig_valid, frame_start, busy, done}

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] repeat_cnt = '0;
   logic [3:0] gap = '0;
   logic       overlap = 1'b0;
   logic       signal, sig_valid, frame_start, busy, done;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];

   sd_1011_gen dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .repeat_cnt  (repeat_cnt),
      .gap         (gap),
      .overlap     (overlap),
      .signal      (signal),
      .sig_valid   (sig_valid),
      .frame_start (frame_start),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input bit s, input bit v, input bit f, input bit b, input bit d);
      return {s, v, f, b, d};
   endfunction

   // Expected per-cycle output stream of one burst, last entry is the done cycle.
   function automatic void model(input int cnt, input int gp, input bit ov, output exp_t q[$]);
      bit [3:0] pat = 4'b1011;
      int frames = (cnt == 0) ? 1 : cnt;
      q.delete();
      for (int f = 0; f < frames; f++) begin
         int first = (f > 0 && gp == 0 && ov) ? 1 : 0;
         for (int k = first; k < 4; k++)
            q.push_back(mk(pat[3-k], 1'b1, k == first, 1'b1, 1'b0));
         if (f < frames - 1)
            for (int g = 0; g < gp; g++) q.push_back(mk(0, 0, 0, 1, 0));
      end
      q.push_back(mk(0, 0, 0, 0, 1));
   endfunction

   always @(negedge clk) begin
      exp_t e;
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if ({signal, sig_valid, frame_start, busy, done} !== e) begin
         errors++;
         $display("FAIL outputs cyc %0d: got {sig,vld,fs,busy,done}=%b want %b",
                  cyc, {signal, sig_valid, frame_start, busy, done}, e);
      end
   end

   task automatic burst(input int cnt, input int gp, input bit ov, input int ab_req, input bit b2b);
      exp_t items[$];
      int   guard = 0;
      int   ab;
      int   active;
      while (sb.size() > (b2b ? 1 : 0)) begin
         @(posedge clk); #1;
         if (++guard > 300) begin
            errors++;
            $display("FAIL drain_timeout: queue %0d entries left, want <= %0d", sb.size(), b2b);
            sb.delete();
         end
      end
      if (!b2b) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      model(cnt, gp, ov, items);
      ab = (ab_req >= 0 && ab_req < items.size() - 1) ? ab_req : -1;
      if (sb.size() == 0) sb.push_back('0);
      active = (ab >= 0) ? ab + 1 : items.size() - 1;
      for (int i = 0; i < active + ((ab >= 0) ? 0 : 1); i++) sb.push_back(items[i]);
      repeat_cnt = 8'(cnt);
      gap        = 4'(gp);
      overlap    = ov;
      start      = 1'b1;
      abort      = 1'($urandom_range(0, 1));   // start wins in IDLE
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < active; i++) begin
         repeat_cnt = 8'($urandom);
         gap        = 4'($urandom);
         overlap    = 1'($urandom);
         start      = ($urandom_range(0, 3) == 0);
         abort      = (i == ab);
         @(posedge clk); #1;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      exp_t items[$];
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Directed bursts
      burst(1, 0, 0, -1, 0);
      burst(3, 0, 1, -1, 0);
      burst(2, 3, 1, -1, 0);
      burst(0, 0, 0, -1, 0);
      burst(4, 0, 0, 6, 0);     // abort on bit 3 of frame 2
      burst(2, 0, 0, -1, 1);    // fresh burst right after abort
      burst(3, 0, 1, -1, 1);    // start in the done cycle
      burst(2, 2, 0, 4, 0);     // abort inside a gap

      // Randomized bursts
      for (int n = 0; n < 40; n++)
         burst($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1,
               1'($urandom));

      // Asynchronous reset mid-gap
      while (sb.size() != 0) begin @(posedge clk); #1; end
      model(3, 5, 0, items);
      sb.push_back('0);
      foreach (items[i]) sb.push_back(items[i]);
      repeat_cnt = 8'd3; gap = 4'd5; overlap = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({signal, sig_valid, frame_start, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset: got %b want 00000", {signal, sig_valid, frame_start, busy, done});
      end
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      repeat (5) @(posedge clk);
      burst(1, 0, 0, -1, 0);
      repeat (8) @(posedge clk);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
      $fatal(1);
   end

endmodule
`default_nettype wire
